// File: rtl/trdb_branch_map.sv
// trdb_branch_map
//   Collects conditional-branch outcomes of retired instructions into a bit
//   map (bit k = k-th recorded branch, 1 = not taken) for the trace encoder.
//   When the priority stage emits a packet (flush_i) the current map and
//   count are copied into snapshot registers and the live map restarts.
//
// Ports
//   clk_i           in   clock, rising edge
//   rst_i           in   synchronous active-high reset
//   valid_i         in   retired instruction presented
//   branch_i        in   instruction is a conditional branch
//   taken_i         in   branch outcome, 1 = taken
//   flush_i         in   packet emitted this cycle, consume the map
//   branch_map_o    out  live branch map
//   branches_o      out  live branch count
//   is_empty_o      out  branches_o == 0
//   is_full_o       out  branches_o == MAP_LEN
//   snap_valid_o    out  one-cycle pulse after a flush
//   snap_map_o      out  map captured at the last flush
//   snap_branches_o out  count captured at the last flush
//   overflow_o      out  sticky: a branch was dropped on a full map
module trdb_branch_map #(
  parameter int MAP_LEN = 31,
  parameter int CNT_W   = 5
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               valid_i,
  input  logic               branch_i,
  input  logic               taken_i,
  input  logic               flush_i,
  output logic [MAP_LEN-1:0] branch_map_o,
  output logic [CNT_W-1:0]   branches_o,
  output logic               is_empty_o,
  output logic               is_full_o,
  output logic               snap_valid_o,
  output logic [MAP_LEN-1:0] snap_map_o,
  output logic [CNT_W-1:0]   snap_branches_o,
  output logic               overflow_o
);

  localparam logic [MAP_LEN-1:0] MAP_ONE = MAP_LEN'(1);
  localparam logic [CNT_W-1:0]   CNT_MAX = CNT_W'(MAP_LEN);

  logic [MAP_LEN-1:0] branch_map, map_nxt, new_bit;
  logic [CNT_W-1:0]   branches, cnt_nxt;
  logic               overflow, ovf_nxt;
  logic               snap_valid;
  logic [MAP_LEN-1:0] snap_map;
  logic [CNT_W-1:0]   snap_branches;
  logic               record, full;

  assign record  = valid_i && branch_i;
  assign full    = (branches == CNT_MAX);
  // Stored polarity is inverted: a set bit marks a not-taken branch.
  assign new_bit = taken_i ? '0 : MAP_ONE;

  always_comb begin
    map_nxt = branch_map;
    cnt_nxt = branches;
    ovf_nxt = overflow;
    if (flush_i) begin
      // A branch arriving with the flush starts the next map; it never
      // lands in the snapshot, so a full map cannot overflow here.
      map_nxt = record ? new_bit : '0;
      cnt_nxt = record ? CNT_W'(1) : '0;
    end else if (record) begin
      if (!full) begin
        map_nxt = branch_map | (new_bit << branches);
        cnt_nxt = branches + CNT_W'(1);
      end else begin
        ovf_nxt = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      branch_map    <= '0;
      branches      <= '0;
      overflow      <= 1'b0;
      snap_valid    <= 1'b0;
      snap_map      <= '0;
      snap_branches <= '0;
    end else begin
      branch_map <= map_nxt;
      branches   <= cnt_nxt;
      overflow   <= ovf_nxt;
      snap_valid <= flush_i;
      if (flush_i) begin
        snap_map      <= branch_map;
        snap_branches <= branches;
      end
    end
  end

  assign branch_map_o    = branch_map;
  assign branches_o      = branches;
  assign is_empty_o      = (branches == '0);
  assign is_full_o       = full;
  assign snap_valid_o    = snap_valid;
  assign snap_map_o      = snap_map;
  assign snap_branches_o = snap_branches;
  assign overflow_o      = overflow;

endmodule

// File: doc/trdb_branch_map.md
TRDB_BRANCH_MAP -- requirements
Module: trdb_branch_map

Interface
REQ-001 SHALL have parameter MAP_LEN, default 31, meaning the maximum number of branch outcomes held (1..31).
REQ-002 SHALL have parameter CNT_W, default 5, meaning the width of the branch counters; SHALL satisfy 2^CNT_W > MAP_LEN.
REQ-003 SHALL have port clk_i  input  1  single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst_i  input  1  synchronous, active-high reset.
REQ-005 SHALL have port valid_i  input  1  a retired instruction is presented this cycle.
REQ-006 SHALL have port branch_i  input  1  the presented instruction is a conditional branch.
REQ-007 SHALL have port taken_i  input  1  branch outcome; 1 = taken.
REQ-008 SHALL have port flush_i  input  1  the priority stage emits a packet this cycle, consuming the map.
REQ-009 SHALL have port branch_map_o  output  MAP_LEN  live map; bit k = outcome of the k-th recorded branch; 1 = NOT taken.
REQ-010 SHALL have port branches_o  output  CNT_W  live number of recorded branches.
REQ-011 SHALL have port is_empty_o  output  1  branches_o == 0; drives tc_branch_map_empty of the priority stage.
REQ-012 SHALL have port is_full_o  output  1  branches_o == MAP_LEN; drives tc_branch_map_full of the priority stage.
REQ-013 SHALL have port snap_valid_o  output  1  one-cycle pulse: snapshot registers hold a flushed map.
REQ-014 SHALL have port snap_map_o  output  MAP_LEN  map captured at the last flush.
REQ-015 SHALL have port snap_branches_o  output  CNT_W  count captured at the last flush.
REQ-016 SHALL have port overflow_o  output  1  sticky: a branch was dropped because the map was full.

Function
REQ-017 SHALL record a branch only when valid_i && branch_i; branch_i and taken_i SHALL be ignored when valid_i = 0.
REQ-018 Record, not full, no flush: branch_map[branches] <= ~taken_i; branches <= branches + 1; visible on the outputs one cycle later.
REQ-019 SHALL derive is_empty_o and is_full_o combinationally from the registered count, with no extra latency.
REQ-020 Flush (flush_i = 1, independent of valid_i): snap_map_o <= branch_map_o and snap_branches_o <= branches_o, both the values held before this edge; snap_valid_o <= 1 for exactly one cycle.
REQ-021 Flush without a recorded branch in the same cycle: map <= 0 and count <= 0.
REQ-022 Flush with a recorded branch in the same cycle: the branch SHALL NOT enter the snapshot; map <= {0..., ~taken_i} and count <= 1.
REQ-023 Record when full without flush: SHALL drop the branch; map and count SHALL be unchanged; overflow_o <= 1.
REQ-024 Record when full with flush: REQ-022 SHALL apply, and overflow_o SHALL NOT be set.
REQ-025 overflow_o SHALL clear only on reset.
REQ-026 SHALL hold snap_map_o and snap_branches_o stable between flushes; snap_valid_o SHALL be 0 in every cycle without a flush on the preceding edge.
REQ-027 Unused map bits at index >= branches_o SHALL read 0.
REQ-028 Count arithmetic SHALL be unsigned; the count SHALL never exceed MAP_LEN and SHALL never wrap.

Reset
REQ-029 On rst_i = 1 at a rising edge: branch_map_o = 0, branches_o = 0, is_empty_o = 1, is_full_o = 0, snap_valid_o = 0, snap_map_o = 0, snap_branches_o = 0, overflow_o = 0.
REQ-030 Reset SHALL take priority over flush_i and over recording; a reset asserted mid-fill SHALL discard the map with no snapshot pulse.

Verification
REQ-031 Record taken, not-taken, taken (MAP_LEN=31) -> branches_o = 3, branch_map_o = 31'b010, is_empty_o = 0.
REQ-032 Record 31 branches, all not taken -> branches_o = 31, branch_map_o = all ones, is_full_o = 1; then one more branch with flush_i = 0 -> state unchanged, overflow_o = 1.
REQ-033 Map holding 5 branches, then flush_i with no branch -> next cycle snap_valid_o = 1, snap_branches_o = 5, snap_map_o = old map; branches_o = 0, is_empty_o = 1; the following cycle snap_valid_o = 0.
REQ-034 Full map, then flush_i together with a not-taken branch -> snap_branches_o = 31; branches_o = 1, branch_map_o = 31'b1, overflow_o = 0.
REQ-035 valid_i = 0 with branch_i = 1 for 10 cycles -> branches_o remains 0.
REQ-036 rst_i asserted together with flush_i and a branch while 7 branches are held -> every output equals its REQ-029 value on the next cycle, and no snap_valid_o pulse occurs.
